// File: rtl/dmem_responder.sv
// Single-port data-memory responder: IDLE -> ACCESS -> RESP handshake for LW/SW requests.
// Optional macro DMEM_RESPONDER_ADDR_CHECK_EN flags requests with nonzero upper address bits.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_nxt;
  logic                  in_reset;
  logic                  accept;
  logic                  cap_we;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [15:0]           cap_wdata;
  logic                  access_err;
  logic [15:0]           rdata_q;
  logic [15:0]           mem [DEPTH];
  logic [15:0]           access_cnt;

  // req_ready stays low for the first cycle after reset releases.
  assign req_ready = (state == IDLE) && !in_reset;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 16'h0000;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = ACCESS;
      ACCESS:                 state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) in_reset <= rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_we    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_we    <= req_we;
      cap_idx   <= req_addr[DEPTH_LOG2-1:0];
      cap_wdata <= req_wdata;
    end
  end

`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
  logic cap_bad;
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)         cap_bad <= 1'b0;
    else if (accept) cap_bad <= (req_addr[15:DEPTH_LOG2] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst)                  err_q <= 1'b0;
    else if (state == ACCESS) err_q <= cap_bad;
  end

  assign access_err = cap_bad;
  assign rsp_err    = rsp_valid && err_q;
`else
  // Upper address bits alias onto the low index when checking is disabled.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[15:DEPTH_LOG2];
  assign access_err     = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  // NOTE: the storage array is reset word-by-word because reset must clear every word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata_q    <= '0;
      access_cnt <= '0;
    end else if (state == ACCESS) begin
      access_cnt <= access_cnt + 16'd1;
      if (cap_we) begin
        if (!access_err) mem[cap_idx] <= cap_wdata;
        rdata_q <= '0;
      end else begin
        rdata_q <= access_err ? 16'h0000 : mem[cap_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder, plus backpressure, reset-mid-op and busy-stream sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [9];

  dmem_responder #(.DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from IDLE and follows it through ACCESS and RESP back to IDLE.
  task automatic do_req(input string tag, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_rdata, input logic exp_err);
    check({tag, " idle req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    check({tag, " access busy/ready/valid"}, {29'd0, busy, req_ready, rsp_valid}, {29'd0, 3'b100});
    tick();
    check({tag, " resp valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, " resp rdata"}, {16'd0, rsp_rdata}, {16'd0, exp_rdata});
    check({tag, " resp err"},   {31'd0, rsp_err}, {31'd0, exp_err});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " back idle ready/valid/rdata"}, {14'd0, req_ready, rsp_valid, rsp_rdata},
          {14'd0, 1'b1, 1'b0, 16'h0000});
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    vecs[0] = '{1'b1, 16'h0003, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 16'h0003, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 16'h0000, 16'h1234, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 16'h000F, 16'hFFFF, 16'h0000, 1'b0};
    vecs[4] = '{1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0};
    vecs[5] = '{1'b0, 16'h000F, 16'h0000, 16'hFFFF, 1'b0};
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
    vecs[6] = '{1'b1, 16'h0013, 16'hAAAA, 16'h0000, 1'b1};
    vecs[7] = '{1'b0, 16'h0003, 16'h0000, 16'hBEEF, 1'b0};
`else
    vecs[6] = '{1'b1, 16'h0013, 16'hAAAA, 16'h0000, 1'b0};
    vecs[7] = '{1'b0, 16'h0003, 16'h0000, 16'hAAAA, 1'b0};
`endif
    vecs[8] = '{1'b0, 16'h0007, 16'h0000, 16'h0000, 1'b0};

    // Reset state
    tick();
    tick();
    check("reset req_ready", {31'd0, req_ready}, 32'd0);
    check("reset busy/valid/err", {29'd0, busy, rsp_valid, rsp_err}, 32'd0);
    check("reset rdata", {16'd0, rsp_rdata}, 32'd0);
    check("reset counter", {16'd0, dut.access_cnt}, 32'd0);
    rst = 1'b0;
    tick();
    check("post-reset req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 9; i++)
      do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, vecs[i].exp_err);
    check("counter after table", {16'd0, dut.access_cnt}, 32'd9);

    // Backpressure: load held in RESP for 5 cycles
    do_req("bp store", 1'b1, 16'h0004, 16'h1234, 16'h0000, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0004;
    tick();
    req_valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp cyc%0d valid/ready/busy", c), {29'd0, rsp_valid, req_ready, busy},
            {29'd0, 3'b101});
      check($sformatf("bp cyc%0d rdata", c), {16'd0, rsp_rdata}, 32'h0000_1234);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp released idle", {29'd0, req_ready, busy, rsp_valid}, {29'd0, 3'b100});

    // Reset asserted during ACCESS of a store
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0005;
    req_wdata = 16'h5555;
    tick();
    req_valid = 1'b0;
    check("rst-mid in access", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check("rst-mid during reset", {29'd0, req_ready, rsp_valid, busy}, 32'd0);
    rst = 1'b0;
    tick();
    check("rst-mid no response", {30'd0, req_ready, rsp_valid}, {30'd0, 2'b10});
    check("rst-mid counter", {16'd0, dut.access_cnt}, 32'd0);

    // Busy stream: req_valid held high with fields changing every cycle
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    for (int k = 0; k < 9; k++) begin
      req_addr  = 16'(k);
      req_wdata = 16'h0100 + 16'(k);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("stream idle", {30'd0, req_ready, busy}, {30'd0, 2'b10});
    check("stream counter", {16'd0, dut.access_cnt}, 32'd3);

    do_req("rst-mid load 5", 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0);
    do_req("stream load 0", 1'b0, 16'h0000, 16'h0000, 16'h0100, 1'b0);
    do_req("stream load 1", 1'b0, 16'h0001, 16'h0000, 16'h0000, 1'b0);
    do_req("stream load 3", 1'b0, 16'h0003, 16'h0000, 16'h0103, 1'b0);
    do_req("stream load 6", 1'b0, 16'h0006, 16'h0000, 16'h0106, 1'b0);
    do_req("cleared load 15", 1'b0, 16'h000F, 16'h0000, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
